// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter serialising single-beat read/write access
// to a small flip-flop register bank. All outputs are registered.
module reg_bank_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic [DATA_W-1:0] RData,
  output logic              RValid,
  output logic              RId
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_prio;
  logic [DEPTH-1:0][DATA_W-1:0]  r_bank;
  logic [DATA_W-1:0]             r_rdata;
  logic                          r_rvalid;
  logic                          r_rid;

  logic                          w_elig0;
  logic                          w_elig1;
  logic                          w_grant;
  logic                          w_sel_id;
  logic                          w_sel_we;
  logic [ADDR_W-1:0]             w_sel_addr;
  logic [DATA_W-1:0]             w_sel_wdata;

  // Next-state arbitration; r_prio names the requester that wins a tie.
  always_comb begin
    w_next      = IDLE;
    w_elig0     = Req0 && (r_state != G0);
    w_elig1     = Req1 && (r_state != G1);
    case ({w_elig0, w_elig1})
      2'b10:   w_next = G0;
      2'b01:   w_next = G1;
      2'b11:   w_next = r_prio ? G1 : G0;
      default: w_next = IDLE;
    endcase
    w_grant  = (w_next != IDLE);
    w_sel_id = (w_next == G1);
    if (w_sel_id) begin
      w_sel_we    = We1;
      w_sel_addr  = Addr1;
      w_sel_wdata = WData1;
    end else begin
      w_sel_we    = We0;
      w_sel_addr  = Addr0;
      w_sel_wdata = WData0;
    end
  end

  // State, pointer, bank and read-return registers; the granted beat executes on entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_bank   <= '0;
      r_rdata  <= {DATA_W{1'b0}};
      r_rvalid <= 1'b0;
      r_rid    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_prio <= ~w_sel_id;
        if (w_sel_we) begin
          r_bank[w_sel_addr] <= w_sel_wdata;
          r_rvalid           <= 1'b0;
        end else begin
          r_rdata  <= r_bank[w_sel_addr];
          r_rvalid <= 1'b1;
          r_rid    <= w_sel_id;
        end
      end else begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign Gnt0   = (r_state == G0);
  assign Gnt1   = (r_state == G1);
  assign RData  = r_rdata;
  assign RValid = r_rvalid;
  assign RId    = r_rid;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Table-driven bench for reg_bank_arbiter: each vector's expected outputs are
// queued when it is driven and checked one cycle later, after the clock edge.
module tb_reg_bank_arbiter;

  logic       Clk;
  logic       Reset;
  logic       Req0, We0, Req1, We1;
  logic [1:0] Addr0, Addr1;
  logic [7:0] WData0, WData1;
  logic       Gnt0, Gnt1, RValid, RId;
  logic [7:0] RData;

  typedef struct {
    logic       rst;
    logic       r0;
    logic       w0;
    logic [1:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic       w1;
    logic [1:0] a1;
    logic [7:0] d1;
    logic       eg0;
    logic       eg1;
    logic       ev;
    logic [7:0] ed;
    logic       eid;
  } vec_t;

  typedef struct {
    logic       eg0;
    logic       eg1;
    logic       ev;
    logic [7:0] ed;
    logic       eid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  reg_bank_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RData(RData), .RValid(RValid), .RId(RId)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic rst, input logic r0, input logic w0,
                              input logic [1:0] a0, input logic [7:0] d0,
                              input logic r1, input logic w1,
                              input logic [1:0] a1, input logic [7:0] d1,
                              input logic eg0, input logic eg1, input logic ev,
                              input logic [7:0] ed, input logic eid);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ev = ev; v.ed = ed; v.eid = eid;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    Reset  = v.rst;
    Req0   = v.r0; We0 = v.w0; Addr0 = v.a0; WData0 = v.d0;
    Req1   = v.r1; We1 = v.w1; Addr1 = v.a1; WData1 = v.d1;
    e.eg0 = v.eg0; e.eg1 = v.eg1; e.ev = v.ev; e.ed = v.ed; e.eid = v.eid;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    got = sb.pop_front();
    n_vec++;
    if (Gnt0 !== got.eg0 || Gnt1 !== got.eg1 || RValid !== got.ev ||
        RData !== got.ed || RId !== got.eid) begin
      n_miss++;
      $display("FAIL %s: got gnt0=%b gnt1=%b rvalid=%b rdata=%h rid=%b, want gnt0=%b gnt1=%b rvalid=%b rdata=%h rid=%b",
               name, Gnt0, Gnt1, RValid, RData, RId,
               got.eg0, got.eg1, got.ev, got.ed, got.eid);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Req0 = 1'b0; We0 = 1'b0; Addr0 = 2'd0; WData0 = 8'h00;
    Req1 = 1'b0; We1 = 1'b0; Addr1 = 2'd0; WData1 = 8'h00;

    //          rst  r0   w0   a0    d0     r1   w1   a1    d1     g0   g1   rv   rd     rid
    vecs.push_back(mk(1'b1,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b0)); // reset
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b0)); // idle
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd2,8'hA5, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,1'b0,8'h00,1'b0)); // wr a2
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd2,8'h00, 1'b0,1'b1,1'b1,8'hA5,1'b1)); // rd a2
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'hA5,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd0,8'h11, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,1'b0,8'hA5,1'b1)); // preload
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b1,2'd1,8'h22, 1'b0,1'b1,1'b0,8'hA5,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'hA5,1'b1));
    for (int k = 0; k < 3; k++) begin // both reading continuously: strict alternation
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b1,1'b0,1'b1,8'h11,1'b0));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b0,1'b1,1'b1,8'h22,1'b1));
    end
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h22,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd3,8'h3C, 1'b1,1'b0,2'd3,8'h00, 1'b1,1'b0,1'b0,8'h22,1'b1)); // wr/rd a3 tie
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd3,8'h00, 1'b0,1'b1,1'b1,8'h3C,1'b1)); // loser next cycle
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h3C,1'b1));
    for (int k = 0; k < 2; k++) begin // Req0 held alone: grant every other cycle
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd2,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,1'b1,8'hA5,1'b0));
      vecs.push_back(mk(1'b0,1'b1,1'b0,2'd2,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'hA5,1'b0));
    end
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'hA5,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd0,8'hFF, 1'b1,1'b1,2'd1,8'hFF, 1'b0,1'b1,1'b0,8'hA5,1'b0)); // fill FF
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd0,8'hFF, 1'b1,1'b1,2'd3,8'hFF, 1'b1,1'b0,1'b0,8'hA5,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd2,8'hFF, 1'b1,1'b1,2'd3,8'hFF, 1'b0,1'b1,1'b0,8'hA5,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b1,2'd2,8'hFF, 1'b1,1'b0,2'd3,8'h00, 1'b1,1'b0,1'b0,8'hA5,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd3,8'h00, 1'b0,1'b1,1'b1,8'hFF,1'b1)); // Gnt1 cycle
    vecs.push_back(mk(1'b1,1'b1,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b0)); // reset wins
    vecs.push_back(mk(1'b0,1'b1,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b1,1'b0,1'b1,8'h00,1'b0)); // tie -> 0
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd1,8'h00, 1'b0,1'b1,1'b1,8'h00,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd3,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd3,8'h00, 1'b0,1'b1,1'b1,8'h00,1'b1));
    vecs.push_back(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Contended loser drops its request before being granted: its write never happens.
    apply(mk(1'b0,1'b1,1'b1,2'd1,8'h77, 1'b1,1'b1,2'd2,8'h88, 1'b1,1'b0,1'b0,8'h00,1'b1), "drop_win");
    apply(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b0,1'b0,1'b0,8'h00,1'b1), "drop_idle");
    apply(mk(1'b0,1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,2'd2,8'h00, 1'b0,1'b1,1'b1,8'h00,1'b1), "drop_rd_a2");
    apply(mk(1'b0,1'b1,1'b0,2'd1,8'h00, 1'b0,1'b0,2'd0,8'h00, 1'b1,1'b0,1'b1,8'h77,1'b0), "drop_rd_a1");

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
